// File: rtl/mips_cpu_lsu_avalon_if.sv
// Bundle of request, result and Avalon-MM signals for the MIPS load/store unit.
// master: the load/store unit itself; slave: the CPU core plus memory side around it.
interface mips_cpu_lsu_avalon_if;
  logic        req_valid;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        load_valid;
  logic [31:0] load_data;
  logic [5:0]  load_opcode;
  logic [1:0]  load_addr_lo;
  logic        store_done;
  logic        addr_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    input  req_valid, req_opcode, req_addr, req_wdata, avm_waitrequest, avm_readdata,
    output busy, load_valid, load_data, load_opcode, load_addr_lo, store_done, addr_error,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output req_valid, req_opcode, req_addr, req_wdata, avm_waitrequest, avm_readdata,
    input  busy, load_valid, load_data, load_opcode, load_addr_lo, store_done, addr_error,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/mips_cpu_lsu_avalon.sv
// MIPS data-memory load/store sequencer: one request at a time, run as a single
// Avalon-MM read or write with waitrequest, optional timeout. Returns the raw word;
// lane extraction and extension happen in the register file.
module mips_cpu_lsu_avalon #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  mips_cpu_lsu_avalon_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERROR} state_t;

  localparam bit                   LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] LP_TO_LAST = TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t r_state, w_state_next;

  // Registered outputs and the latched request context
  logic                 r_busy, w_busy_next;
  logic                 r_load_valid, w_load_valid_next;
  logic [31:0]          r_load_data, w_load_data_next;
  logic [5:0]           r_load_opcode, w_load_opcode_next;
  logic [1:0]           r_load_addr_lo, w_load_addr_lo_next;
  logic                 r_store_done, w_store_done_next;
  logic                 r_addr_error, w_addr_error_next;
  logic [31:0]          r_avm_address, w_avm_address_next;
  logic                 r_avm_read, w_avm_read_next;
  logic                 r_avm_write, w_avm_write_next;
  logic [31:0]          r_avm_writedata, w_avm_writedata_next;
  logic [3:0]           r_avm_byteenable, w_avm_byteenable_next;
  logic [TIMEOUT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic                 r_is_load, w_is_load_next;
  logic [5:0]           r_opcode, w_opcode_next;
  logic [1:0]           r_addr_lo, w_addr_lo_next;
  logic [31:0]          r_rdata, w_rdata_next;

  // Decode of the incoming request
  logic        w_is_load, w_is_store, w_misaligned, w_accept, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Opcode decode: access type, alignment fault, lane enables and replicated store data
  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = 32'h0;
    case (bus.req_opcode)
      6'b100000, 6'b100010, 6'b100100, 6'b100110: w_is_load = 1'b1;
      6'b100001, 6'b100101: begin
        w_is_load    = 1'b1;
        w_misaligned = bus.req_addr[0];
      end
      6'b100011: begin
        w_is_load    = 1'b1;
        w_misaligned = (bus.req_addr[1:0] != 2'b00);
      end
      6'b101000: begin
        w_is_store = 1'b1;
        w_be       = 4'b0001 << bus.req_addr[1:0];
        w_wdata    = {4{bus.req_wdata[7:0]}};
      end
      6'b101001: begin
        w_is_store   = 1'b1;
        w_misaligned = bus.req_addr[0];
        w_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{bus.req_wdata[15:0]}};
      end
      6'b101011: begin
        w_is_store   = 1'b1;
        w_misaligned = (bus.req_addr[1:0] != 2'b00);
        w_wdata      = bus.req_wdata;
      end
      default: ;
    endcase
  end

  // The result pulse cycle keeps busy high, so a request is only taken once busy has dropped
  assign w_accept  = (r_state == S_IDLE) && !r_busy && bus.req_valid && (w_is_load || w_is_store);
  assign w_timeout = LP_TO_EN && bus.avm_waitrequest && (r_wait_cnt >= LP_TO_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = w_misaligned ? S_ERROR : S_ACCESS;
      S_ACCESS: begin
        if (!bus.avm_waitrequest) w_state_next = S_DONE;
        else if (w_timeout)       w_state_next = S_ERROR;
      end
      S_DONE:   w_state_next = S_IDLE;
      S_ERROR:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered bus strobes, pulses and result fields
  always_comb begin
    w_load_valid_next     = 1'b0;
    w_store_done_next     = 1'b0;
    w_addr_error_next     = 1'b0;
    w_load_data_next      = r_load_data;
    w_load_opcode_next    = r_load_opcode;
    w_load_addr_lo_next   = r_load_addr_lo;
    w_avm_address_next    = r_avm_address;
    w_avm_read_next       = r_avm_read;
    w_avm_write_next      = r_avm_write;
    w_avm_writedata_next  = r_avm_writedata;
    w_avm_byteenable_next = r_avm_byteenable;
    w_wait_cnt_next       = r_wait_cnt;
    w_is_load_next        = r_is_load;
    w_opcode_next         = r_opcode;
    w_addr_lo_next        = r_addr_lo;
    w_rdata_next          = r_rdata;
    w_busy_next           = (w_state_next != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_misaligned) begin
          w_avm_address_next    = {bus.req_addr[31:2], 2'b00};
          w_avm_read_next       = w_is_load;
          w_avm_write_next      = w_is_store;
          w_avm_writedata_next  = w_wdata;
          w_avm_byteenable_next = w_be;
          w_wait_cnt_next       = '0;
          w_is_load_next        = w_is_load;
          w_opcode_next         = bus.req_opcode;
          w_addr_lo_next        = bus.req_addr[1:0];
        end
      end
      S_ACCESS: begin
        if (!bus.avm_waitrequest) begin
          w_avm_read_next  = 1'b0;
          w_avm_write_next = 1'b0;
          if (r_is_load) w_rdata_next = bus.avm_readdata;
        end else begin
          if (!(&r_wait_cnt)) w_wait_cnt_next = r_wait_cnt + 1'b1;
          if (w_timeout) begin
            w_avm_read_next  = 1'b0;
            w_avm_write_next = 1'b0;
          end
        end
      end
      S_DONE: begin
        w_busy_next       = 1'b1;
        w_load_valid_next = r_is_load;
        w_store_done_next = !r_is_load;
        if (r_is_load) begin
          w_load_data_next    = r_rdata;
          w_load_opcode_next  = r_opcode;
          w_load_addr_lo_next = r_addr_lo;
        end
      end
      S_ERROR: begin
        w_busy_next       = 1'b1;
        w_addr_error_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and context registers; async reset abandons any transfer without pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy           <= 1'b0;
      r_load_valid     <= 1'b0;
      r_load_data      <= '0;
      r_load_opcode    <= '0;
      r_load_addr_lo   <= '0;
      r_store_done     <= 1'b0;
      r_addr_error     <= 1'b0;
      r_avm_address    <= '0;
      r_avm_read       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_writedata  <= '0;
      r_avm_byteenable <= '0;
      r_wait_cnt       <= '0;
      r_is_load        <= 1'b0;
      r_opcode         <= '0;
      r_addr_lo        <= '0;
      r_rdata          <= '0;
    end else begin
      r_busy           <= w_busy_next;
      r_load_valid     <= w_load_valid_next;
      r_load_data      <= w_load_data_next;
      r_load_opcode    <= w_load_opcode_next;
      r_load_addr_lo   <= w_load_addr_lo_next;
      r_store_done     <= w_store_done_next;
      r_addr_error     <= w_addr_error_next;
      r_avm_address    <= w_avm_address_next;
      r_avm_read       <= w_avm_read_next;
      r_avm_write      <= w_avm_write_next;
      r_avm_writedata  <= w_avm_writedata_next;
      r_avm_byteenable <= w_avm_byteenable_next;
      r_wait_cnt       <= w_wait_cnt_next;
      r_is_load        <= w_is_load_next;
      r_opcode         <= w_opcode_next;
      r_addr_lo        <= w_addr_lo_next;
      r_rdata          <= w_rdata_next;
    end
  end

  assign bus.busy           = r_busy;
  assign bus.load_valid     = r_load_valid;
  assign bus.load_data      = r_load_data;
  assign bus.load_opcode    = r_load_opcode;
  assign bus.load_addr_lo   = r_load_addr_lo;
  assign bus.store_done     = r_store_done;
  assign bus.addr_error     = r_addr_error;
  assign bus.avm_address    = r_avm_address;
  assign bus.avm_read       = r_avm_read;
  assign bus.avm_write      = r_avm_write;
  assign bus.avm_writedata  = r_avm_writedata;
  assign bus.avm_byteenable = r_avm_byteenable;

endmodule

// File: tb/tb_mips_cpu_lsu_avalon.sv
// Directed bench for mips_cpu_lsu_avalon: expected bus transfers and load results are
// queued when a request is driven and popped when the bus monitor / result pulse shows them.
module tb_mips_cpu_lsu_avalon;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_cpu_lsu_avalon_if bus ();

  mips_cpu_lsu_avalon #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [5:0] OP_LH = 6'b100001, OP_LW = 6'b100011, OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;

  typedef struct packed {logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data;} txn_t;
  typedef struct packed {logic [31:0] data; logic [5:0] op; logic [1:0] lo;} ld_t;

  txn_t exp_q[$], cap_q[$];
  ld_t  exp_ld[$];
  int   n_assert = 0, n_fail = 0;
  int   cnt_rd = 0, cnt_wr = 0, cnt_lv = 0, both_high = 0, stable_viol = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;
  logic [31:0] lv_data;
  logic [5:0]  lv_op;
  logic [1:0]  lv_lo;

  // Bus monitor: counts strobe cycles, checks stability under waitrequest, records completed transfers
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_read) cnt_rd++;
      if (bus.avm_write) cnt_wr++;
      if (bus.avm_read && bus.avm_write) both_high++;
      if (bus.load_valid) cnt_lv++;
      if ((bus.avm_read || bus.avm_write) && prev_hold &&
          (bus.avm_address != prev_addr || bus.avm_byteenable != prev_be || bus.avm_writedata != prev_wdata))
        stable_viol++;
      if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest)
        cap_q.push_back('{bus.avm_write, bus.avm_address, bus.avm_byteenable,
                          bus.avm_write ? bus.avm_writedata : 32'h0});
      prev_hold  = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      prev_be    = bus.avm_byteenable;
      prev_wdata = bus.avm_writedata;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop one expected and one captured bus transfer and compare them field by field
  task automatic check_bus(input string tag);
    txn_t e, c;
    check({tag, "_captured"}, 32'(cap_q.size() > 0), 32'd1);
    if (cap_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cap_q.pop_front();
      check({tag, "_wr"}, 32'(c.wr), 32'(e.wr));
      check({tag, "_addr"}, c.addr, e.addr);
      check({tag, "_be"}, 32'(c.be), 32'(e.be));
      check({tag, "_wdata"}, c.data, e.data);
    end
  endtask

  task automatic check_load(input string tag);
    ld_t e;
    check({tag, "_ldq"}, 32'(exp_ld.size() > 0), 32'd1);
    if (exp_ld.size() > 0) begin
      e = exp_ld.pop_front();
      check({tag, "_ldata"}, lv_data, e.data);
      check({tag, "_lop"}, 32'(lv_op), 32'(e.op));
      check({tag, "_llo"}, 32'(lv_lo), 32'(e.lo));
    end
  endtask

  // Issue one request; waitrequest high for the first 'waits' ACCESS cycles.
  // kind: 1 load_valid, 2 store_done, 3 addr_error, 4 several at once; latencies in edges after accept.
  task automatic run_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits,
                         output int kind, output int pulse_lat, output int busy_lat);
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.avm_readdata = rdata; bus.avm_waitrequest = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.avm_waitrequest = (waits > 0);
    kind = 0; pulse_lat = -1; busy_lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      bus.avm_waitrequest = (i < waits);
      if (pulse_lat < 0 && (bus.load_valid || bus.store_done || bus.addr_error)) begin
        pulse_lat = i;
        kind = (32'(bus.load_valid) + 32'(bus.store_done) + 32'(bus.addr_error) > 1) ? 4 :
               bus.load_valid ? 1 : bus.store_done ? 2 : 3;
        lv_data = bus.load_data; lv_op = bus.load_opcode; lv_lo = bus.load_addr_lo;
      end
      if (!bus.busy) begin
        busy_lat = i;
        break;
      end
    end
    bus.avm_waitrequest = 1'b0;
  endtask

  initial begin
    int kind, pl, bl, rd0, wr0, lv0;
    logic seen;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_read", 32'(bus.avm_read), 32'd0);
    check("rst_write", 32'(bus.avm_write), 32'd0);
    check("rst_pulses", {29'd0, bus.load_valid, bus.store_done, bus.addr_error}, 32'd0);
    check("rst_load_data", bus.load_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: sw, zero wait states
    exp_q.push_back('{1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});
    run_req(OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, kind, pl, bl);
    check("sw_kind", kind, 2); check("sw_pulse_lat", pl, 2); check("sw_busy_lat", bl, 3);
    check_bus("sw");
    $display("txn sw   addr=%h kind=%0d pulse=%0d busy=%0d", 32'h100, kind, pl, bl);

    // 2: sb at lane 3
    exp_q.push_back('{1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5});
    run_req(OP_SB, 32'h103, 32'h000000A5, 32'h0, 0, kind, pl, bl);
    check("sb_kind", kind, 2); check_bus("sb");
    $display("txn sb   addr=%h kind=%0d pulse=%0d busy=%0d", 32'h103, kind, pl, bl);

    // 3: sh upper half
    exp_q.push_back('{1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF});
    run_req(OP_SH, 32'h102, 32'h0000BEEF, 32'h0, 0, kind, pl, bl);
    check("sh_kind", kind, 2); check_bus("sh");
    $display("txn sh   addr=%h kind=%0d pulse=%0d busy=%0d", 32'h102, kind, pl, bl);

    // 4: lw with three wait states
    rd0 = cnt_rd;
    exp_q.push_back('{1'b0, 32'h200, 4'b1111, 32'h0});
    exp_ld.push_back('{32'h12345678, OP_LW, 2'b00});
    run_req(OP_LW, 32'h200, 32'h0, 32'h12345678, 3, kind, pl, bl);
    check("lw_kind", kind, 1); check("lw_pulse_lat", pl, 5); check("lw_busy_lat", bl, 6);
    check("lw_read_cycles", cnt_rd - rd0, 4);
    check_bus("lw"); check_load("lw");
    $display("txn lw   addr=%h kind=%0d pulse=%0d busy=%0d", 32'h200, kind, pl, bl);

    // 5: misaligned lh faults with no bus read
    rd0 = cnt_rd;
    run_req(OP_LH, 32'h201, 32'h0, 32'h0, 0, kind, pl, bl);
    check("lh_err_kind", kind, 3); check("lh_err_reads", cnt_rd - rd0, 0);
    check("lh_err_nobus", cap_q.size(), 0); check("lh_err_busy_fell", 32'(bl > 0), 32'd1);
    $display("txn lh   addr=%h kind=%0d pulse=%0d busy=%0d", 32'h201, kind, pl, bl);

    // 6: misaligned sw faults with no bus write
    wr0 = cnt_wr;
    run_req(OP_SW, 32'h202, 32'h11111111, 32'h0, 0, kind, pl, bl);
    check("sw_err_kind", kind, 3); check("sw_err_writes", cnt_wr - wr0, 0);
    check("sw_err_nobus", cap_q.size(), 0);
    $display("txn sw   addr=%h kind=%0d pulse=%0d busy=%0d", 32'h202, kind, pl, bl);

    // 7: lwr at byte 3 never faults
    exp_q.push_back('{1'b0, 32'h200, 4'b1111, 32'h0});
    exp_ld.push_back('{32'hA1B2C3D4, OP_LWR, 2'b11});
    run_req(OP_LWR, 32'h203, 32'h0, 32'hA1B2C3D4, 0, kind, pl, bl);
    check("lwr_kind", kind, 1); check("lwr_pulse_lat", pl, 2);
    check_bus("lwr"); check_load("lwr");
    $display("txn lwr  addr=%h kind=%0d pulse=%0d busy=%0d", 32'h203, kind, pl, bl);

    // Unsupported opcode (addi) is ignored
    rd0 = cnt_rd; wr0 = cnt_wr;
    bus.req_valid = 1'b1; bus.req_opcode = 6'b001000; bus.req_addr = 32'h40;
    tick();
    bus.req_valid = 1'b0;
    check("badop_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    check("badop_strobes", (cnt_rd - rd0) + (cnt_wr - wr0), 0);
    check("badop_pulses", {29'd0, bus.load_valid, bus.store_done, bus.addr_error}, 32'd0);
    $display("txn addi addr=%h ignored busy=%0d", 32'h40, bus.busy);

    // 8: timeout after 4 waitrequest cycles
    rd0 = cnt_rd;
    run_req(OP_LW, 32'h280, 32'h0, 32'h0, 100, kind, pl, bl);
    check("to_kind", kind, 3); check("to_read_cycles", cnt_rd - rd0, 4);
    check("to_pulse_lat", pl, 5); check("to_busy_lat", bl, 6);
    check("to_nobus", cap_q.size(), 0);
    $display("txn lw   addr=%h timeout kind=%0d pulse=%0d busy=%0d", 32'h280, kind, pl, bl);

    // 9: async reset mid-access
    bus.req_valid = 1'b1; bus.req_opcode = OP_LW; bus.req_addr = 32'h300;
    bus.avm_waitrequest = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    check("rstmid_read_before", 32'(bus.avm_read), 32'd1);
    lv0 = cnt_lv;
    reset_n = 1'b0;
    #1;
    check("rstmid_read_async", 32'(bus.avm_read), 32'd0);
    check("rstmid_busy_async", 32'(bus.busy), 32'd0);
    tick();
    reset_n = 1'b1; bus.avm_waitrequest = 1'b0;
    repeat (3) tick();
    check("rstmid_no_load_valid", cnt_lv - lv0, 0);
    check("rstmid_nobus", cap_q.size(), 0);
    exp_q.push_back('{1'b0, 32'h304, 4'b1111, 32'h0});
    exp_ld.push_back('{32'hCAFEF00D, OP_LW, 2'b00});
    run_req(OP_LW, 32'h304, 32'h0, 32'hCAFEF00D, 0, kind, pl, bl);
    check("rstmid_next_kind", kind, 1); check("rstmid_next_lat", pl, 2);
    check_bus("rstmid_next"); check_load("rstmid_next");
    $display("txn lw   addr=%h after reset kind=%0d pulse=%0d busy=%0d", 32'h304, kind, pl, bl);

    // 10: req_valid held through a busy load; only one transfer
    wr0 = cnt_wr; lv0 = cnt_lv;
    exp_q.push_back('{1'b0, 32'h400, 4'b1111, 32'h0});
    exp_ld.push_back('{32'h0BADF00D, OP_LW, 2'b00});
    bus.req_valid = 1'b1; bus.req_opcode = OP_LW; bus.req_addr = 32'h400;
    bus.avm_readdata = 32'h0BADF00D; bus.avm_waitrequest = 1'b0;
    tick();
    bus.req_opcode = OP_SW; bus.req_addr = 32'h500; bus.req_wdata = 32'h5555AAAA;
    seen = 1'b0; bl = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.load_valid && !seen) begin
        seen = 1'b1;
        lv_data = bus.load_data; lv_op = bus.load_opcode; lv_lo = bus.load_addr_lo;
      end
      if (!bus.busy) begin
        bl = i;
        break;
      end
    end
    bus.req_valid = 1'b0;
    repeat (3) tick();
    check("hold_busy_lat", bl, 3); check("hold_seen", 32'(seen), 32'd1);
    check("hold_no_write", cnt_wr - wr0, 0); check("hold_one_load", cnt_lv - lv0, 1);
    check_bus("hold"); check_load("hold");
    check("hold_single_txn", cap_q.size(), 0);
    $display("txn lw   addr=%h held-req busy=%0d loads=%0d", 32'h400, bl, cnt_lv - lv0);

    check("never_rd_and_wr", both_high, 0);
    check("stable_under_wait", stable_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
